// File: rtl/mac_ctrl_36.sv
// mac_ctrl_36: job controller for an external N-lane multiplier array.
// Operand beats are registered onto the array inputs. A valid pipe
// tracks which products are in flight. Returning products are summed
// per lane into two accumulator banks. The sums are presented with a
// valid/ready handshake, and a one-cycle done pulse marks acceptance.
module mac_ctrl_36 #(
    parameter int N       = 36,
    parameter int MUL_LAT = 3,
    parameter int ACC_W   = 24,
    parameter int LEN_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [LEN_W-1:0]   len,
    output logic               busy,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [8*N-1:0]     s_a,
    input  logic [8*N-1:0]     s_b,
    input  logic [8*N-1:0]     s_c,
    output logic [8*N-1:0]     mul_a,
    output logic [8*N-1:0]     mul_b,
    output logic [8*N-1:0]     mul_c,
    input  logic [16*N-1:0]    mul_p1,
    input  logic [16*N-1:0]    mul_p2,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [ACC_W*N-1:0] m_acc1,
    output logic [ACC_W*N-1:0] m_acc2,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    localparam logic [LEN_W-1:0] C_LEN_ONE = LEN_W'(1);

    state_t               r_state;
    state_t               w_next;
    logic [LEN_W-1:0]     r_len;
    logic [LEN_W-1:0]     r_cnt;
    logic [MUL_LAT-1:0]   r_vpipe;
    logic [8*N-1:0]       r_mul_a;
    logic [8*N-1:0]       r_mul_b;
    logic [8*N-1:0]       r_mul_c;
    logic [ACC_W*N-1:0]   r_acc1;
    logic [ACC_W*N-1:0]   r_acc2;
    logic                 r_busy;
    logic                 r_s_ready;
    logic                 r_m_valid;
    logic                 r_done;

    logic                 w_hs;
    logic                 w_start_ok;
    logic                 w_accept;
    logic                 w_tail;
    logic                 w_last_beat;

    // A beat transfers only while the registered ready is up (FEED).
    assign w_hs        = r_s_ready & s_valid;
    // busy also covers the done cycle, so a start there is refused too.
    assign w_start_ok  = (r_state == IDLE) & ~r_busy & start & (len != '0);
    assign w_accept    = (r_state == OUT) & m_ready;
    assign w_tail      = r_vpipe[MUL_LAT-1];
    assign w_last_beat = ((r_cnt + C_LEN_ONE) == r_len);

    assign busy    = r_busy;
    assign s_ready = r_s_ready;
    assign m_valid = r_m_valid;
    assign done    = r_done;
    assign mul_a   = r_mul_a;
    assign mul_b   = r_mul_b;
    assign mul_c   = r_mul_c;
    assign m_acc1  = r_acc1;
    assign m_acc2  = r_acc2;

    // Next-state decode for the job sequencer.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_start_ok) begin
                    w_next = FEED;
                end else begin
                    w_next = IDLE;
                end
            end
            FEED: begin
                if (w_hs && w_last_beat) begin
                    w_next = DRAIN;
                end else begin
                    w_next = FEED;
                end
            end
            DRAIN: begin
                // An empty pipe means the final product was summed last edge.
                if (r_vpipe == '0) begin
                    w_next = OUT;
                end else begin
                    w_next = DRAIN;
                end
            end
            OUT: begin
                if (m_ready) begin
                    w_next = IDLE;
                end else begin
                    w_next = OUT;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // State register and registered control outputs, decoded from next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_s_ready <= 1'b0;
            r_m_valid <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_busy    <= (w_next != IDLE) | w_accept;
            r_s_ready <= (w_next == FEED);
            r_m_valid <= (w_next == OUT);
            r_done    <= w_accept;
        end
    end

    // Datapath: operand registers, valid pipe, beat counter, accumulators.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len   <= '0;
            r_cnt   <= '0;
            r_vpipe <= '0;
            r_mul_a <= '0;
            r_mul_b <= '0;
            r_mul_c <= '0;
            r_acc1  <= '0;
            r_acc2  <= '0;
        end else if (w_start_ok) begin
            r_len   <= len;
            r_cnt   <= '0;
            r_vpipe <= '0;
            r_acc1  <= '0;
            r_acc2  <= '0;
        end else begin
            // Pipe stage k holds "a valid operand set entered k+1 edges ago".
            r_vpipe[0] <= w_hs;
            for (int k = 1; k < MUL_LAT; k++) begin
                r_vpipe[k] <= r_vpipe[k-1];
            end
            if (w_hs) begin
                r_mul_a <= s_a;
                r_mul_b <= s_b;
                r_mul_c <= s_c;
                r_cnt   <= r_cnt + C_LEN_ONE;
            end
            if (w_tail) begin
                for (int i = 0; i < N; i++) begin
                    r_acc1[i*ACC_W +: ACC_W] <= r_acc1[i*ACC_W +: ACC_W]
                                                + ACC_W'(mul_p1[i*16 +: 16]);
                    r_acc2[i*ACC_W +: ACC_W] <= r_acc2[i*ACC_W +: ACC_W]
                                                + ACC_W'(mul_p2[i*16 +: 16]);
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_ctrl_36.sv
// Testbench for mac_ctrl_36. A behavioural multiplier array returns
// products MUL_LAT cycles after the operands change. Expected sums are
// queued when a job is driven and compared when the result is accepted.
module tb_mac_ctrl_36;

    localparam int N       = 36;
    localparam int MUL_LAT = 3;
    localparam int ACC_W   = 18;
    localparam int LEN_W   = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [LEN_W-1:0]   len = '0;
    logic               busy;
    logic               s_valid = 1'b0;
    logic               s_ready;
    logic [8*N-1:0]     s_a = '0;
    logic [8*N-1:0]     s_b = '0;
    logic [8*N-1:0]     s_c = '0;
    logic [8*N-1:0]     mul_a;
    logic [8*N-1:0]     mul_b;
    logic [8*N-1:0]     mul_c;
    logic [16*N-1:0]    mul_p1;
    logic [16*N-1:0]    mul_p2;
    logic               m_valid;
    logic               m_ready = 1'b1;
    logic [ACC_W*N-1:0] m_acc1;
    logic [ACC_W*N-1:0] m_acc2;
    logic               done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc = 0;
    int last_hs_cyc = 0;
    int done_cnt = 0;
    int mv_rise_cnt = 0;
    int hs_cnt = 0;
    logic exp_done = 1'b0;
    logic prev_mv = 1'b0;

    logic [ACC_W*N-1:0] exp1_q[$];
    logic [ACC_W*N-1:0] exp2_q[$];

    mac_ctrl_36 #(.N(N), .MUL_LAT(MUL_LAT), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .busy(busy),
        .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b), .s_c(s_c),
        .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c),
        .mul_p1(mul_p1), .mul_p2(mul_p2),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_acc1(m_acc1), .m_acc2(m_acc2), .done(done)
    );

    always #5 clk = ~clk;

    // Multiplier array model: combinational products delayed MUL_LAT-1 edges.
    function automatic logic [16*N-1:0] vmul(input logic [8*N-1:0] x, input logic [8*N-1:0] y);
        logic [16*N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            r[i*16 +: 16] = 16'(x[i*8 +: 8]) * 16'(y[i*8 +: 8]);
        end
        return r;
    endfunction

    logic [16*N-1:0] p1_d [0:MUL_LAT-2];
    logic [16*N-1:0] p2_d [0:MUL_LAT-2];

    // Product delay line of the modelled multiplier array.
    always @(posedge clk) begin
        p1_d[0] <= vmul(mul_a, mul_b);
        p2_d[0] <= vmul(mul_a, mul_c);
        for (int k = 1; k < MUL_LAT-1; k++) begin
            p1_d[k] <= p1_d[k-1];
            p2_d[k] <= p2_d[k-1];
        end
    end
    assign mul_p1 = p1_d[MUL_LAT-2];
    assign mul_p2 = p2_d[MUL_LAT-2];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: sampled on the falling edge, when all inputs and outputs are stable.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                exp_done = 1'b0;
                prev_mv  = 1'b0;
            end else begin
                if (done) done_cnt++;
                if (exp_done) begin
                    check_eq("done_pulse", done, 1);
                    check_eq("mvalid_after_accept", m_valid, 0);
                    check_eq("busy_in_done_cycle", busy, 1);
                    exp_done = 1'b0;
                end
                if (s_valid && s_ready) begin
                    hs_cnt++;
                    last_hs_cyc = cyc + 1;
                end
                if (m_valid && !prev_mv) begin
                    mv_rise_cnt++;
                    check_eq("mvalid_latency", cyc - last_hs_cyc, MUL_LAT + 1);
                end
                if (m_valid && m_ready) begin
                    if (exp1_q.size() == 0) begin
                        check_eq("unexpected_result", 1, 0);
                    end else begin
                        logic [ACC_W*N-1:0] e1;
                        logic [ACC_W*N-1:0] e2;
                        e1 = exp1_q.pop_front();
                        e2 = exp2_q.pop_front();
                        for (int i = 0; i < N; i++) begin
                            check_eq($sformatf("acc1_lane%0d", i), m_acc1[i*ACC_W +: ACC_W], e1[i*ACC_W +: ACC_W]);
                            check_eq($sformatf("acc2_lane%0d", i), m_acc2[i*ACC_W +: ACC_W], e2[i*ACC_W +: ACC_W]);
                        end
                    end
                    exp_done = 1'b1;
                end
                prev_mv = m_valid;
            end
        end
    end

    task automatic start_job(input int l);
        start = 1'b1;
        len   = LEN_W'(l);
        tick();
        start = 1'b0;
    endtask

    task automatic drive_beat(input logic [8*N-1:0] a, input logic [8*N-1:0] b,
                              input logic [8*N-1:0] c, input int gap);
        int t;
        t = 0;
        s_valid = 1'b1;
        s_a = a; s_b = b; s_c = c;
        while (!s_ready && t < 50) begin
            tick();
            t++;
        end
        check_eq("beat_ready_timeout", (t < 50), 1);
        tick();
        s_valid = 1'b0;
        s_a = ~a; s_b = ~b; s_c = ~c;
        check_eq("mul_a_loaded", mul_a[63:0], a[63:0]);
        repeat (gap) tick();
        if (gap > 0) check_eq("mul_b_held", mul_b[63:0], b[63:0]);
    endtask

    // mode 0: 3/4/5, mode 1: all 255, otherwise random per lane and beat.
    task automatic drive_job(input int l, input int gap, input int mode);
        logic [8*N-1:0]     aq[$];
        logic [8*N-1:0]     bq[$];
        logic [8*N-1:0]     cq[$];
        logic [8*N-1:0]     av, bv, cv;
        logic [ACC_W*N-1:0] e1, e2;
        e1 = '0;
        e2 = '0;
        for (int k = 0; k < l; k++) begin
            for (int i = 0; i < N; i++) begin
                case (mode)
                    0: begin av[i*8 +: 8] = 8'd3;   bv[i*8 +: 8] = 8'd4;   cv[i*8 +: 8] = 8'd5;   end
                    1: begin av[i*8 +: 8] = 8'd255; bv[i*8 +: 8] = 8'd255; cv[i*8 +: 8] = 8'd255; end
                    default: begin
                        av[i*8 +: 8] = 8'($urandom_range(0, 255));
                        bv[i*8 +: 8] = 8'($urandom_range(0, 255));
                        cv[i*8 +: 8] = 8'($urandom_range(0, 255));
                    end
                endcase
                e1[i*ACC_W +: ACC_W] = e1[i*ACC_W +: ACC_W] + ACC_W'(16'(av[i*8 +: 8]) * 16'(bv[i*8 +: 8]));
                e2[i*ACC_W +: ACC_W] = e2[i*ACC_W +: ACC_W] + ACC_W'(16'(av[i*8 +: 8]) * 16'(cv[i*8 +: 8]));
            end
            aq.push_back(av); bq.push_back(bv); cq.push_back(cv);
        end
        exp1_q.push_back(e1);
        exp2_q.push_back(e2);
        start_job(l);
        for (int k = 0; k < l; k++) begin
            drive_beat(aq[k], bq[k], cq[k], gap);
        end
        check_eq("sready_low_after_last", s_ready, 0);
    endtask

    task automatic wait_done(input int target);
        int t;
        t = 0;
        while (done_cnt < target && t < 200) begin
            tick();
            t++;
        end
        check_eq("done_timeout", (done_cnt >= target), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, h0, r0;
        logic [ACC_W*N-1:0] snap1, snap2;
        int t;

        // Reset state
        repeat (3) tick();
        check_eq("rst_busy", busy, 0);
        check_eq("rst_sready", s_ready, 0);
        check_eq("rst_mvalid", m_valid, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_acc1", m_acc1[63:0], 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Single beat, 3*4 and 3*5 per lane
        drive_job(1, 0, 0);
        wait_done(1);
        repeat (3) tick();
        check_eq("hold_acc1_l0", m_acc1[ACC_W-1:0], 12);
        check_eq("hold_acc2_l35", m_acc2[35*ACC_W +: ACC_W], 15);
        check_eq("idle_busy", busy, 0);

        // Gapped beats at full scale
        h0 = hs_cnt;
        drive_job(4, 2, 1);
        check_eq("gapped_handshakes", hs_cnt - h0, 4);
        wait_done(2);
        check_eq("gapped_acc1_l0", m_acc1[ACC_W-1:0], 260100);

        // Accumulator wrap at 18 bits
        drive_job(5, 0, 1);
        wait_done(3);
        check_eq("wrap_acc1_l0", m_acc1[ACC_W-1:0], 62981);

        // Random jobs
        for (int j = 0; j < 3; j++) begin
            drive_job($urandom_range(1, 6), $urandom_range(0, 2), 2);
            wait_done(4 + j);
        end

        // Output back-pressure with start pulses while busy
        m_ready = 1'b0;
        drive_job(2, 0, 2);
        t = 0;
        while (!m_valid && t < 50) begin
            tick();
            t++;
        end
        check_eq("stall_mvalid_timeout", m_valid, 1);
        snap1 = m_acc1;
        snap2 = m_acc2;
        d0 = done_cnt;
        for (int k = 0; k < 10; k++) begin
            start = (k % 3 == 0);
            len   = 8'd3;
            tick();
            check_eq("stall_mvalid", m_valid, 1);
            check_eq("stall_sready", s_ready, 0);
            check_eq("stall_data", (m_acc1 == snap1) && (m_acc2 == snap2), 1);
        end
        start = 1'b0;
        m_ready = 1'b1;
        wait_done(d0 + 1);
        repeat (4) tick();
        check_eq("stall_single_done", done_cnt - d0, 1);
        check_eq("stall_start_ignored", busy, 0);
        check_eq("stall_no_feed", s_ready, 0);

        // Zero-length start is ignored
        d0 = done_cnt;
        start_job(0);
        for (int k = 0; k < 4; k++) begin
            check_eq("len0_busy", busy, 0);
            check_eq("len0_sready", s_ready, 0);
            tick();
        end
        check_eq("len0_no_done", done_cnt - d0, 0);

        // Asynchronous reset in the middle of FEED
        d0 = done_cnt;
        r0 = mv_rise_cnt;
        start_job(6);
        drive_beat({N{8'hFF}}, {N{8'hFF}}, {N{8'hFF}}, 0);
        drive_beat({N{8'hFF}}, {N{8'hFF}}, {N{8'hFF}}, 0);
        check_eq("pre_rst_sready", s_ready, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_busy", busy, 0);
        check_eq("arst_sready", s_ready, 0);
        check_eq("arst_mvalid", m_valid, 0);
        check_eq("arst_done", done, 0);
        check_eq("arst_mul_a", mul_a[63:0], 0);
        check_eq("arst_acc1", m_acc1[63:0], 0);
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check_eq("arst_no_done", done_cnt - d0, 0);
        check_eq("arst_no_mvalid", mv_rise_cnt - r0, 0);
        check_eq("scoreboard_drained", exp1_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_ctrl_36.md
MAC_CTRL_36 -- requirements
Module: mac_ctrl_36

Interface
REQ-001 SHALL have parameter N, default 36, the number of multiplier lanes.
REQ-002 SHALL have parameter MUL_LAT, default 3, the cycles from mul_a/mul_b/mul_c changing to mul_p1/mul_p2 being valid.
REQ-003 SHALL have parameter ACC_W, default 24, the per-product accumulator width.
REQ-004 SHALL have parameter LEN_W, default 8, the width of the beat-count input.
REQ-005 SHALL have ports:
- clk  in  1  sole clock; rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  job request; sampled only in IDLE.
- len  in  LEN_W  beats per job; sampled with start.
- busy  out  1  high whenever state is not IDLE.
- s_valid  in  1  operand beat valid.
- s_ready  out  1  operand beat accepted when s_valid and s_ready are both high.
- s_a, s_b, s_c  in  8*N each  operand vectors; lane i is bits [8i+7:8i].
- mul_a, mul_b, mul_c  out  8*N each  registered operands to the multiplier array.
- mul_p1, mul_p2  in  16*N each  array products: p1 = a*b, p2 = a*c, per lane, unsigned.
- m_valid  out  1  result valid.
- m_ready  in  1  result accepted.
- m_acc1, m_acc2  out  ACC_W*N each  per-lane sums of p1 and p2.
- done  out  1  one-cycle pulse on result acceptance.

Function
REQ-006 SHALL implement the states IDLE, FEED, DRAIN and OUT.
REQ-007 In IDLE, start=1 with len!=0 SHALL latch len, clear all accumulators and the valid pipe, and go to FEED; start with len=0 SHALL be ignored.
REQ-008 In FEED, s_ready SHALL be 1; each handshake SHALL register s_a/s_b/s_c onto mul_a/mul_b/mul_c, push 1 into a MUL_LAT-deep valid pipe, and increment the beat count.
REQ-009 In FEED, a cycle without a handshake SHALL push 0 into the pipe and hold mul_* unchanged.
REQ-010 The handshake on beat len SHALL move the state to DRAIN; s_ready SHALL be 0 in every state except FEED.
REQ-011 When the pipe tail is 1, each lane SHALL add zero-extended mul_p1 to acc1 and mul_p2 to acc2 at that edge; sums SHALL wrap modulo 2^ACC_W with no saturation.
REQ-012 DRAIN SHALL go to OUT on the edge after the last valid product has been accumulated.
- With no stalls, m_valid SHALL rise MUL_LAT+1 cycles after the final handshake edge.
REQ-013 In OUT, m_valid SHALL be 1, and m_acc1/m_acc2 SHALL stay stable until m_ready=1.
- On that edge: done=1 for exactly one cycle, state goes to IDLE, m_valid goes to 0.
REQ-014 m_acc1/m_acc2 SHALL hold their values after OUT and be cleared only at the next job start.
REQ-015 start SHALL be ignored whenever busy=1.
REQ-016 busy SHALL be 1 from the cycle after an accepted start through the cycle in which done=1.

Reset
REQ-017 rst_n=0 SHALL asynchronously force:
- state IDLE;
- busy, s_ready, m_valid, done = 0;
- mul_*, accumulators, valid pipe, beat count = 0.
REQ-018 Deassertion of rst_n SHALL take effect on a clock edge; reset asserted mid-job SHALL abandon the job with no done pulse and no m_valid.

Verification
REQ-019 Reset: assert rst_n=0 mid-FEED with no clock edge -> all outputs listed in REQ-017 are 0 immediately.
REQ-020 len=1, all lanes a=3, b=4, c=5, m_ready=1 -> every lane m_acc1=12, m_acc2=15; m_valid rises MUL_LAT+1 cycles after the handshake; done follows.
REQ-021 len=4, s_valid gapped 1-on/2-off, a=b=c=255 -> every lane m_acc1=m_acc2=260100; exactly 4 handshakes; s_ready=0 after the 4th.
REQ-022 Build with ACC_W=18, len=5, a=b=255 -> m_acc1=62981 per lane (wrap).
REQ-023 m_ready held 0 for 10 cycles in OUT, start pulsed during that time -> m_valid and data stable, s_ready=0, start ignored; done pulses once when m_ready=1.
REQ-024 start with len=0 -> busy stays 0, no s_ready, no done.
